spi_param_regs: RTL and testbench

SPI responder (slave) that lets an external controller write and read back servo and sweep parameters over a 4-wire SPI link, replacing hard-wired parameter constants. It sits between the board's host-controller SPI pins and the servo datapath (PI/PD coefficients, sweep min/max/stepsize). Writes land in a shadow bank and are copied to the active bank only on a COMMIT write, so multi-word coefficients change atomically. It is the responder counterpart of the SPI initiators that configure the ADC and DAC.

---
 rtl/spi_param_pkg.sv | 20 ++
 rtl/spi_param_regs_if.sv | 27 ++
 rtl/spi_sync.sv | 35 +++
 rtl/spi_param_regs.sv | 144 ++++++++++++++
 tb/tb_spi_param_regs.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_param_pkg.sv
// Shared constants and FSM encoding for the SPI parameter register block.
// Frame layout: R/W bit, 7-bit address, 16-bit data, MSB first.
package spi_param_pkg;

    localparam int FRAME_BITS = 24;
    localparam int ADDR_BITS  = 7;
    localparam int HDR_BITS   = 8;

    localparam logic [ADDR_BITS-1:0] ADDR_COMMIT = 7'h7F;
    localparam logic [ADDR_BITS-1:0] ADDR_ID     = 7'h7E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_param_regs_if.sv
// Host-side 4-wire SPI pins of the parameter register block.
// The host controller is the master; the register block is the slave.
interface spi_param_regs_if;

    logic spi_sck_in;
    logic spi_scs_in;
    logic spi_sdi_in;
    logic spi_sdo_out;
    logic spi_sdo_oe_out;

    modport slave (
        input  spi_sck_in,
        input  spi_scs_in,
        input  spi_sdi_in,
        output spi_sdo_out,
        output spi_sdo_oe_out
    );

    modport master (
        output spi_sck_in,
        output spi_scs_in,
        output spi_sdi_in,
        input  spi_sdo_out,
        input  spi_sdo_oe_out
    );

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer followed by a registered edge detector.
// level, rise and fall are mutually aligned, three clk_in cycles after the pin changes.
module spi_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Flops reset low, so a pin held low through reset never produces a fall.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= sig;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
            fall <= ~sync & prev;
        end
    end

    assign level = prev;

endmodule

// File: rtl/spi_param_regs.sv
// SPI mode-0 responder holding servo/sweep parameters in a shadow bank,
// copied atomically to the active bank by a write to ADDR_COMMIT.
module spi_param_regs
    import spi_param_pkg::*;
#(
    parameter int          NREGS    = 16,
    parameter logic [15:0] ID_VALUE = 16'hA5C3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    spi_param_regs_if.slave       spi,
    output logic [16*NREGS-1:0]   regs_out,
    output logic                  update_out,
    output logic                  frame_err_out
);

    localparam int              IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [6:0]      NREGS_A = 7'(NREGS);

    logic sck_level, sck_rise, sck_fall;
    logic scs_level, scs_rise, scs_fall;
    logic sdi_level, sdi_rise, sdi_fall;
    logic unused_sync;

    spi_sync u_sck (.clk_in(clk_in), .rst_in(rst_in), .sig(spi.spi_sck_in),
                    .level(sck_level), .rise(sck_rise), .fall(sck_fall));
    spi_sync u_scs (.clk_in(clk_in), .rst_in(rst_in), .sig(spi.spi_scs_in),
                    .level(scs_level), .rise(scs_rise), .fall(scs_fall));
    spi_sync u_sdi (.clk_in(clk_in), .rst_in(rst_in), .sig(spi.spi_sdi_in),
                    .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall));

    assign unused_sync = ^{sck_level, sdi_rise, sdi_fall};

    state_t                  state, state_nxt;
    logic [4:0]              bit_cnt;
    logic [14:0]             rx;
    logic                    hdr_rw;
    logic [6:0]              hdr_addr;
    logic [15:0]             tx;
    logic                    sdo_q;
    logic                    sdo_oe;
    logic [NREGS-1:0][15:0]  shadow;
    logic [NREGS-1:0][15:0]  active;

    logic                    in_frame, shift_en, hdr_done, last_bit, wr_en, frame_err_nxt;
    logic [6:0]              rd_addr;
    logic [15:0]             rd_word, wr_data;

    // rx holds only the bits still needed: header bits at the 8th edge, data bits at the 24th.
    always_comb begin
        in_frame      = (state == ST_HEADER) || (state == ST_WDATA) || (state == ST_RDATA);
        shift_en      = sck_rise && !scs_level && in_frame;
        hdr_done      = shift_en && (state == ST_HEADER) && (bit_cnt == 5'(HDR_BITS - 1));
        last_bit      = shift_en && (state != ST_HEADER) && (bit_cnt == 5'(FRAME_BITS - 1));
        wr_en         = last_bit && (state == ST_WDATA);
        wr_data       = {rx, sdi_level};
        rd_addr       = {rx[5:0], sdi_level};
        frame_err_nxt = scs_rise && (((state == ST_HEADER) && (bit_cnt != 5'd0)) ||
                                     (state == ST_WDATA) || (state == ST_RDATA));
        rd_word       = 16'h0000;
        if (rd_addr < NREGS_A) begin
            rd_word = active[rd_addr[IDX_W-1:0]];
        end else if (rd_addr == ADDR_ID) begin
            rd_word = ID_VALUE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (scs_fall) state_nxt = ST_HEADER;
            ST_HEADER: if (hdr_done) state_nxt = rx[6] ? ST_RDATA : ST_WDATA;
            ST_WDATA:  if (last_bit) state_nxt = ST_DONE;
            ST_RDATA:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_DONE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (scs_level) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bit_cnt       <= 5'd0;
            rx            <= '0;
            hdr_rw        <= 1'b0;
            hdr_addr      <= '0;
            tx            <= '0;
            sdo_q         <= 1'b0;
            shadow        <= '0;
            active        <= '0;
            update_out    <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            update_out    <= 1'b0;
            frame_err_out <= frame_err_nxt;

            if (scs_level || scs_fall) begin
                bit_cnt <= 5'd0;
            end else if (shift_en && (bit_cnt != 5'(FRAME_BITS))) begin
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (shift_en) begin
                rx <= {rx[13:0], sdi_level};
            end

            // The read word is captured at the 8th edge so bit 15 is ready for the next fall.
            if (hdr_done) begin
                hdr_rw   <= rx[6];
                hdr_addr <= rd_addr;
                tx       <= rd_word;
                sdo_q    <= 1'b0;
            end else if (sck_fall && (state == ST_RDATA)) begin
                sdo_q <= tx[15];
                tx    <= {tx[14:0], 1'b0};
            end

            if (wr_en) begin
                if (hdr_addr < NREGS_A) begin
                    shadow[hdr_addr[IDX_W-1:0]] <= wr_data;
                end else if (hdr_addr == ADDR_COMMIT) begin
                    active     <= shadow;
                    update_out <= 1'b1;
                end
            end
        end
    end

    assign sdo_oe             = (state == ST_RDATA) || ((state == ST_DONE) && hdr_rw);
    assign spi.spi_sdo_oe_out = sdo_oe;
    assign spi.spi_sdo_out    = sdo_oe && sdo_q;
    assign regs_out           = active;

endmodule

// File: tb/tb_spi_param_regs.sv
// Scoreboard bench for spi_param_regs: directed SPI frames push expected events,
// separate monitors pop and compare on update/frame-error pulses and completed read frames.
module tb_spi_param_regs;

    localparam int NREGS = 16;
    localparam int RW    = 16 * NREGS;

    typedef enum {EV_UPDATE, EV_READ, EV_ERR} ev_t;
    typedef struct {
        ev_t          kind;
        logic [255:0] value;
    } exp_t;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [RW-1:0]   regs_out;
    logic            update_out;
    logic            frame_err_out;

    exp_t            exp_q[$];
    int              n_cmp  = 0;
    int              n_fail = 0;
    logic [255:0]    exp_regs;

    int              mon_bits = 0;
    logic            mon_rw   = 1'b0;
    logic [15:0]     mon_word = 16'h0;

    spi_param_regs_if spi_bus ();

    spi_param_regs #(.NREGS(NREGS), .ID_VALUE(16'hA5C3)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .spi           (spi_bus),
        .regs_out      (regs_out),
        .update_out    (update_out),
        .frame_err_out (frame_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectEvent(input ev_t kind, input logic [255:0] value);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic popEvent(input ev_t kind, input logic [255:0] actual);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL unexpected_%s: got %0h, expected no event", kind.name(), actual);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL event_order: got %s, expected %s", kind.name(), e.kind.name());
            end else begin
                checkOutput(kind.name(), actual, e.value);
            end
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic frameStart();
        spi_bus.spi_scs_in = 1'b0;
        waitClk(8);
    endtask

    task automatic sendBit(input logic b);
        spi_bus.spi_sdi_in = b;
        waitClk(8);
        spi_bus.spi_sck_in = 1'b1;
        waitClk(8);
        spi_bus.spi_sck_in = 1'b0;
    endtask

    task automatic frameEnd();
        waitClk(8);
        spi_bus.spi_scs_in = 1'b1;
        spi_bus.spi_sdi_in = 1'b0;
        waitClk(12);
    endtask

    // One frame of nbits sck pulses; bits past 24 are driven as ones.
    task automatic applyStimulus(input logic [23:0] frame, input int nbits);
        logic hdr_oe;
        logic data_oe;
        hdr_oe  = 1'b0;
        data_oe = 1'b0;
        frameStart();
        for (int i = 0; i < nbits; i++) begin
            if (i < 8 && spi_bus.spi_sdo_oe_out) hdr_oe = 1'b1;
            if (i == 12) data_oe = spi_bus.spi_sdo_oe_out;
            sendBit(i < 24 ? frame[23 - i] : 1'b1);
        end
        frameEnd();
        if (frame[23] && nbits >= 24) begin
            checkOutput("oe_header", 256'(hdr_oe), 256'(0));
            checkOutput("oe_data", 256'(data_oe), 256'(1));
        end
    endtask

    task automatic commitExpect(input logic [255:0] regs);
        expectEvent(EV_UPDATE, regs);
        applyStimulus(24'h7F0000, 24);
    endtask

    task automatic readExpect(input logic [6:0] addr, input logic [15:0] word);
        expectEvent(EV_READ, 256'(word));
        applyStimulus({1'b1, addr, 16'h0000}, 24);
    endtask

    always @(negedge spi_bus.spi_scs_in) mon_bits = 0;

    always @(posedge spi_bus.spi_sck_in) begin
        if (spi_bus.spi_scs_in === 1'b0) begin
            if (mon_bits == 0) mon_rw = spi_bus.spi_sdi_in;
            else if (mon_bits >= 8 && mon_bits < 24) mon_word = {mon_word[14:0], spi_bus.spi_sdo_out};
            if (mon_bits < 24) mon_bits++;
        end
    end

    always @(posedge spi_bus.spi_scs_in) begin
        if (mon_bits >= 24 && mon_rw) popEvent(EV_READ, 256'(mon_word));
    end

    always @(negedge clk_in) begin
        if (rst_in === 1'b1) begin
            if (update_out) popEvent(EV_UPDATE, regs_out);
            if (frame_err_out) popEvent(EV_ERR, 256'(frame_err_out));
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_in             = 1'b0;
        spi_bus.spi_sck_in = 1'b0;
        spi_bus.spi_scs_in = 1'b1;
        spi_bus.spi_sdi_in = 1'b0;
        waitClk(5);
        checkOutput("rst_regs", regs_out, 256'(0));
        checkOutput("rst_update", 256'(update_out), 256'(0));
        checkOutput("rst_err", 256'(frame_err_out), 256'(0));
        checkOutput("rst_sdo", 256'(spi_bus.spi_sdo_out), 256'(0));
        checkOutput("rst_oe", 256'(spi_bus.spi_sdo_oe_out), 256'(0));
        rst_in = 1'b1;
        waitClk(5);

        $display("[TB] write 0x1234 to addr 3, then commit");
        applyStimulus(24'h031234, 24);
        checkOutput("regs_pre_commit", regs_out, 256'(0));
        exp_regs = 256'h1234 << 48;
        commitExpect(exp_regs);

        $display("[TB] shadow write to addr 0 is invisible until commit");
        applyStimulus(24'h00BEEF, 24);
        readExpect(7'h00, 16'h0000);
        exp_regs = (256'h1234 << 48) | 256'hBEEF;
        commitExpect(exp_regs);
        readExpect(7'h00, 16'hBEEF);
        readExpect(7'h03, 16'h1234);

        $display("[TB] ID and unmapped reads");
        readExpect(7'h7E, 16'hA5C3);
        readExpect(7'h20, 16'h0000);

        $display("[TB] write aborted after 12 bits");
        expectEvent(EV_ERR, 256'(1));
        applyStimulus(24'h05FFFF, 12);
        commitExpect(exp_regs);
        applyStimulus(24'h055A5A, 24);
        exp_regs = exp_regs | (256'h5A5A << 80);
        commitExpect(exp_regs);

        $display("[TB] 30 sck pulses in one write frame");
        applyStimulus(24'h07CAFE, 30);
        exp_regs = exp_regs | (256'hCAFE << 112);
        commitExpect(exp_regs);

        $display("[TB] reset at bit 10 of a write frame");
        frameStart();
        for (int i = 0; i < 10; i++) sendBit(i < 8 ? (i == 4) : (i == 9));
        rst_in = 1'b0;
        waitClk(4);
        checkOutput("mid_rst_regs", regs_out, 256'(0));
        checkOutput("mid_rst_update", 256'(update_out), 256'(0));
        checkOutput("mid_rst_oe", 256'(spi_bus.spi_sdo_oe_out), 256'(0));
        checkOutput("mid_rst_sdo", 256'(spi_bus.spi_sdo_out), 256'(0));
        rst_in = 1'b1;
        waitClk(2);
        for (int i = 10; i < 24; i++) sendBit(1'b1);
        frameEnd();
        exp_regs = 256'(0);
        commitExpect(exp_regs);
        applyStimulus(24'h081111, 24);
        exp_regs = 256'h1111 << 128;
        commitExpect(exp_regs);
        readExpect(7'h08, 16'h1111);

        waitClk(20);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL missing_%s: got no event, expected %0h", e.kind.name(), e.value);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
